// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Optional CR->CRLF expansion in uart_tx_queue is enabled with UART_TXQ_CRLF_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } txq_state_t;

    localparam int unsigned CLKS_PER_BIT_DEF = 10416;
    localparam int unsigned FRAME_BITS_DEF   = 10;
    localparam int unsigned BYTE_W           = 8;

    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Write-side and sender-side signals of the UART transmit queue.
interface uart_tx_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          ovf_clr;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    modport master (
        output wr_data, wr_en, ovf_clr,
        input  tx_data, tx_start, full, count, overflow, busy
    );

    modport slave (
        input  wr_data, wr_en, ovf_clr,
        output tx_data, tx_start, full, count, overflow, busy
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags; push while full is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_c,
    output logic [CW-1:0]    o_count,
    output logic [CW-1:0]    o_count_nxt_c,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_pop         = i_pop && !r_empty;
    assign w_push        = i_push && (!r_full || w_pop);
    assign o_count_nxt_c = r_count + CW'(w_push) - CW'(w_pop);
    assign o_head_c      = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_full        = r_full;
    assign o_empty       = r_empty;

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= o_count_nxt_c;
            r_full  <= (o_count_nxt_c == CW'(DEPTH));
            r_empty <= (o_count_nxt_c == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue pacing bytes into a busy-less UART sender, one per frame time.
// Define UART_TXQ_CRLF_EN to follow every transmitted CR with an inserted LF.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FRAME_BITS   = FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_queue_if.slave    io_bus
);

    localparam int unsigned FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int unsigned FCW          = $clog2(FRAME_CYCLES);
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    txq_state_t        r_state;
    txq_state_t        w_state_nxt;
    logic [FCW-1:0]    r_frame_cnt;
    logic [FCW-1:0]    w_frame_cnt_nxt;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_tx_data_nxt;
    logic              r_tx_start;
    logic              w_tx_start_nxt;
    logic              r_overflow;
    logic              r_busy;

    logic [BYTE_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_launch;
    logic              w_frame_last;
    logic              w_ovf_set;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (io_bus.wr_en),
        .i_data        (io_bus.wr_data),
        .i_pop         (w_pop),
        .o_head_c      (w_head),
        .o_count       (w_count),
        .o_count_nxt_c (w_count_nxt),
        .o_full        (w_full),
        .o_empty       (w_empty)
    );

`ifdef UART_TXQ_CRLF_EN
    logic r_pending_lf;
    logic w_pending_lf_nxt;

    assign w_launch = r_pending_lf || !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending_lf <= 1'b0;
        end else begin
            r_pending_lf <= w_pending_lf_nxt;
        end
    end
`else
    assign w_launch = !w_empty;
`endif

    assign w_frame_last = (r_frame_cnt == FCW'(FRAME_CYCLES - 2));
    // A write into a full FIFO survives only if the IDLE pop frees a slot that cycle.
    assign w_ovf_set    = io_bus.wr_en && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = SEND;
            SEND:    w_state_nxt = WAIT;
            WAIT:    if (w_frame_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, the frame counter and the pop strobe.
    always_comb begin
        w_pop           = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
`ifdef UART_TXQ_CRLF_EN
        w_pending_lf_nxt = r_pending_lf;
`endif
        case (r_state)
            IDLE: begin
`ifdef UART_TXQ_CRLF_EN
                if (r_pending_lf) begin
                    w_tx_data_nxt    = ASCII_LF;
                    w_tx_start_nxt   = 1'b1;
                    w_pending_lf_nxt = 1'b0;
                end else if (!w_empty) begin
                    w_pop            = 1'b1;
                    w_tx_data_nxt    = w_head;
                    w_tx_start_nxt   = 1'b1;
                    w_pending_lf_nxt = (w_head == ASCII_CR);
                end
`else
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_tx_data_nxt  = w_head;
                    w_tx_start_nxt = 1'b1;
                end
`endif
            end
            SEND:    w_frame_cnt_nxt = '0;
            WAIT:    w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
            default: w_frame_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_overflow  <= w_ovf_set || (r_overflow && !io_bus.ovf_clr);
            r_busy      <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
        end
    end

    assign io_bus.tx_data  = r_tx_data;
    assign io_bus.tx_start = r_tx_start;
    assign io_bus.full     = w_full;
    assign io_bus.count    = w_count;
    assign io_bus.overflow = r_overflow;
    assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed corner cases and random traffic
// checked against a queue-based reference model.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FB    = 10;
    localparam int          FC    = 40;
`ifdef UART_TXQ_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk;
    logic rst;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // reference model state
    logic [7:0] m_q[$];
    bit         m_pend;
    bit         m_ovf;
    int         m_next_pop;
    logic       e_start;
    logic [7:0] e_data;

    int         s_cyc[$];
    logic [7:0] s_dat[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic we, input logic [7:0] d, input logic clr);
        rst         = r;
        bus.wr_en   = we;
        bus.wr_data = d;
        bus.ovf_clr = clr;
    endtask

    // Model: a launch may happen once a full frame slot plus the SEND cycle has passed.
    task automatic model_step();
        int  sz;
        bit  fifo_pop;
        bit  drop;
        logic [7:0] b;
        if (rst) begin
            m_q.delete();
            m_pend     = 1'b0;
            m_ovf      = 1'b0;
            m_next_pop = cyc + 1;
            e_start    = 1'b0;
            e_data     = 8'h00;
        end else begin
            sz       = m_q.size();
            fifo_pop = 1'b0;
            drop     = 1'b0;
            e_start  = 1'b0;
            if (cyc >= m_next_pop && (m_pend || sz != 0)) begin
                if (m_pend) begin
                    e_data = 8'h0A;
                    m_pend = 1'b0;
                end else begin
                    b        = m_q.pop_front();
                    e_data   = b;
                    fifo_pop = 1'b1;
                    m_pend   = CRLF && (b == 8'h0D);
                end
                e_start    = 1'b1;
                m_next_pop = cyc + 1 + FC;
            end
            if (bus.wr_en) begin
                if (sz < DEPTH || fifo_pop) m_q.push_back(bus.wr_data);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("tx_start", 32'(bus.tx_start), 32'(e_start));
        chk("tx_data",  32'(bus.tx_data),  32'(e_data));
        chk("count",    32'(bus.count),    32'(m_q.size()));
        chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("busy",     32'(bus.busy),     32'((cyc < m_next_pop) || (m_q.size() != 0)));
        if (bus.tx_start === 1'b1) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(bus.tx_data);
        end
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int limit);
        bit done;
        done = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < limit && !done; i++) begin
            tick();
            if (bus.busy === 1'b0 && m_q.size() == 0 && !m_pend) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic check_sent(input string name, input logic [7:0] exp[$]);
        chk({name, "_n"}, 32'(s_dat.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < s_dat.size(); i++) begin
            chk({name, "_data"}, 32'(s_dat[i]), 32'(exp[i]));
            if (i > 0) chk({name, "_gap"}, 32'(s_cyc[i] - s_cyc[i-1]), 32'(FC + 1));
        end
    endtask

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        int         reps;
        logic       start;
        logic [7:0] data;
        int         count;
        logic       full;
        logic       ovf;
        logic       busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] exp[$];
        int nw;
        int rate;

        set_in(1'b1, 1'b0, 8'h00, 1'b0);

        // reset, then a single byte: tx_start two cycles after the write, idle 42 after
        vecs[0] = '{1'b1, 1'b1, 8'hFF, 1'b0, 3,  1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1,  1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b1, 8'hA5, 0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 38, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b0, 8'hA5, 0, 1'b0, 1'b0, 1'b0};
        for (int v = 0; v < 7; v++) begin
            set_in(vecs[v].rst, vecs[v].wr_en, vecs[v].wr_data, vecs[v].ovf_clr);
            for (int r = 0; r < vecs[v].reps; r++) tick();
            chk("vec_start", 32'(bus.tx_start), 32'(vecs[v].start));
            chk("vec_data",  32'(bus.tx_data),  32'(vecs[v].data));
            chk("vec_count", 32'(bus.count),    32'(vecs[v].count));
            chk("vec_full",  32'(bus.full),     32'(vecs[v].full));
            chk("vec_ovf",   32'(bus.overflow), 32'(vecs[v].ovf));
            chk("vec_busy",  32'(bus.busy),     32'(vecs[v].busy));
        end

        // burst of three bytes
        s_cyc.delete(); s_dat.delete();
        set_in(1'b0, 1'b1, 8'h55, 1'b0); tick();
        set_in(1'b0, 1'b1, 8'hAA, 1'b0); tick();
        set_in(1'b0, 1'b1, 8'h0F, 1'b0); tick();
        drain(400);
        exp = '{8'h55, 8'hAA, 8'h0F};
        check_sent("burst", exp);
        if (s_cyc.size() == 3) chk("burst_span", 32'(s_cyc[2] - s_cyc[0]), 32'd82);

        // overflow during WAIT, then clear
        s_cyc.delete(); s_dat.delete();
        set_in(1'b0, 1'b1, 8'h11, 1'b0); tick();
        idle(5);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b1, 8'h21 + 8'(i), 1'b0);
            tick();
        end
        chk("ovf_count", 32'(bus.count), 32'd4);
        chk("ovf_full",  32'(bus.full), 32'd1);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        set_in(1'b0, 1'b0, 8'h00, 1'b1); tick();
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        drain(400);
        exp = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        check_sent("ovf", exp);

        // write while full, in the IDLE pop cycle
        s_cyc.delete(); s_dat.delete();
        set_in(1'b0, 1'b1, 8'h31, 1'b0); tick();
        idle(3);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 8'h32 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100 && cyc != m_next_pop; i++) tick();
        chk("fp_pre_full", 32'(bus.full), 32'd1);
        set_in(1'b0, 1'b1, 8'h77, 1'b0); tick();
        chk("fp_ovf",   32'(bus.overflow), 32'd0);
        chk("fp_count", 32'(bus.count), 32'd4);
        drain(500);
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h77};
        check_sent("fullpop", exp);

        // CR handling
        s_cyc.delete(); s_dat.delete();
        set_in(1'b0, 1'b1, 8'h0D, 1'b0); tick();
        set_in(1'b0, 1'b1, 8'h41, 1'b0); tick();
        drain(400);
        if (CRLF) exp = '{8'h0D, 8'h0A, 8'h41};
        else      exp = '{8'h0D, 8'h41};
        check_sent("crlf", exp);

        // reset mid-WAIT flushes the queue
        set_in(1'b0, 1'b1, 8'h5A, 1'b0); tick();
        idle(10);
        set_in(1'b0, 1'b1, 8'h5B, 1'b0); tick();
        idle(3);
        set_in(1'b1, 1'b1, 8'hEE, 1'b0); tick();
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_data",  32'(bus.tx_data),  32'd0);
        chk("rst_count", 32'(bus.count),    32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        s_cyc.delete(); s_dat.delete();
        idle(60);
        chk("rst_nostart", 32'(s_cyc.size()), 32'd0);
        nw = cyc;
        set_in(1'b0, 1'b1, 8'h66, 1'b0); tick();
        idle(3);
        chk("rst_new_n", 32'(s_cyc.size()), 32'd1);
        if (s_cyc.size() != 0) begin
            chk("rst_new_lat",  32'(s_cyc[0]), 32'(nw + 2));
            chk("rst_new_data", 32'(s_dat[0]), 32'h66);
        end
        drain(200);

        // random traffic against the model
        rate = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = ($urandom_range(0, 2) == 0) ? 40 : (($urandom_range(0, 1) == 0) ? 5 : 2);
            set_in($urandom_range(0, 599) == 0,
                   $urandom_range(0, 99) < rate,
                   ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom),
                   $urandom_range(0, 39) == 0);
            tick();
        end
        drain(600);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
